regfile_writeback: RTL

Write-back stage that owns the single write port of the 32×32 MIPS register file. Merges two result producers onto that port: the single-cycle ALU path, which has priority, and the long-latency memory/mul-div path, which is buffered in a small FIFO. Keeps a pending-write scoreboard so the decode stage can stall on registers whose long-latency result has not yet been written. Register `$0` is never written and is never busy.

---
 rtl/mips_pkg.sv | 11 +
 rtl/regfile_writeback_if.sv | 29 ++
 rtl/wb_fifo.sv | 60 ++++++
 rtl/regfile_writeback.sv | 102 ++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions: register-file geometry and the write-back entry type.
package mips_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;
  localparam int NREGS      = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] wa;
    logic [DATA_W-1:0]     wd;
  } wb_entry_t;
endpackage

// File: rtl/regfile_writeback_if.sv
// Bundle of producer, issue and register-file write-port signals around the write-back stage.
interface regfile_writeback_if #(parameter int DEPTH = 4);
  import mips_pkg::*;

  logic                    alu_valid;
  logic [REG_ADDR_W-1:0]   alu_wa;
  logic [DATA_W-1:0]       alu_wd;
  logic                    mem_valid;
  logic                    mem_ready;
  logic [REG_ADDR_W-1:0]   mem_wa;
  logic [DATA_W-1:0]       mem_wd;
  logic                    iss_valid;
  logic [REG_ADDR_W-1:0]   iss_wa;
  logic                    writeReg;
  logic [REG_ADDR_W-1:0]   wa;
  logic [DATA_W-1:0]       wd;
  logic [NREGS-1:0]        busy;
  logic [$clog2(DEPTH):0]  fifo_count;

  modport master (
    output alu_valid, alu_wa, alu_wd, mem_valid, mem_wa, mem_wd, iss_valid, iss_wa,
    input  mem_ready, writeReg, wa, wd, busy, fifo_count
  );

  modport slave (
    input  alu_valid, alu_wa, alu_wd, mem_valid, mem_wa, mem_wd, iss_valid, iss_wa,
    output mem_ready, writeReg, wa, wd, busy, fifo_count
  );
endinterface

// File: rtl/wb_fifo.sv
// Small synchronous FIFO buffering long-latency results; full/empty derive from the occupancy count.
module wb_fifo
  import mips_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = wb_entry_t
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  entry_t                 din,
  output entry_t                 dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [AW:0]   CNT_MAX = (AW+1)'(DEPTH);

  entry_t        mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   count_r;

  // Entry storage; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointers wrap modulo DEPTH; count tracks simultaneous push/pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  assign dout  = mem_r[rd_ptr_r];
  assign count = count_r;
  assign full  = (count_r == CNT_MAX);
  assign empty = (count_r == '0);
endmodule

// File: rtl/regfile_writeback.sv
// Write-back stage: ALU-priority arbitration onto the register-file write port, plus pending-write scoreboard.
module regfile_writeback
  import mips_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  regfile_writeback_if.slave bus
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic                  push_s;
  logic                  pop_s;
  logic                  full_s;
  logic                  empty_s;
  wb_entry_t             din_s;
  wb_entry_t             head_s;
  logic [CW-1:0]         count_s;
  logic                  sel_valid_s;
  logic [REG_ADDR_W-1:0] sel_wa_s;
  logic [DATA_W-1:0]     sel_wd_s;
  logic [NREGS-1:0]      busy_next_s;
  logic [NREGS-1:0]      busy_r;
  logic                  write_reg_r;
  logic [REG_ADDR_W-1:0] wa_r;
  logic [DATA_W-1:0]     wd_r;

  assign bus.mem_ready = !full_s && !rst;
  assign push_s        = bus.mem_valid && !full_s && !rst;
  assign pop_s         = !bus.alu_valid && !empty_s;
  assign din_s         = {bus.mem_wa, bus.mem_wd};

  wb_fifo #(.DEPTH(DEPTH), .entry_t(wb_entry_t)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .pop   (pop_s),
    .din   (din_s),
    .dout  (head_s),
    .count (count_s),
    .full  (full_s),
    .empty (empty_s)
  );

  // Port arbitration: ALU wins, otherwise drain the FIFO head.
  always_comb begin
    sel_valid_s = 1'b0;
    sel_wa_s    = '0;
    sel_wd_s    = '0;
    if (bus.alu_valid) begin
      sel_valid_s = 1'b1;
      sel_wa_s    = bus.alu_wa;
      sel_wd_s    = bus.alu_wd;
    end else if (pop_s) begin
      sel_valid_s = 1'b1;
      sel_wa_s    = head_s.wa;
      sel_wd_s    = head_s.wd;
    end else begin
      sel_valid_s = 1'b0;
    end
  end

  // Scoreboard update: clear on pop, then set on issue so a same-cycle set wins.
  always_comb begin
    busy_next_s = busy_r;
    if (pop_s) begin
      busy_next_s[head_s.wa] = 1'b0;
    end else begin
      busy_next_s = busy_r;
    end
    if (bus.iss_valid && (bus.iss_wa != '0)) begin
      busy_next_s[bus.iss_wa] = 1'b1;
    end else begin
      busy_next_s[0] = 1'b0;
    end
    busy_next_s[0] = 1'b0;
  end

  // Registered write port and scoreboard; $0 selections are consumed without a write.
  always_ff @(posedge clk) begin
    if (rst) begin
      write_reg_r <= 1'b0;
      wa_r        <= '0;
      wd_r        <= '0;
      busy_r      <= '0;
    end else begin
      write_reg_r <= sel_valid_s && (sel_wa_s != '0);
      if (sel_valid_s) begin
        wa_r <= sel_wa_s;
        wd_r <= sel_wd_s;
      end
      busy_r <= busy_next_s;
    end
  end

  assign bus.writeReg   = write_reg_r;
  assign bus.wa         = wa_r;
  assign bus.wd         = wd_r;
  assign bus.busy       = busy_r;
  assign bus.fifo_count = count_s;
endmodule
